dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signal bundle for the shared data-memory port.
// A requester's access is accepted in the cycle gnt[i]=1, and the arbiter drives the
// memory port in that same cycle. rvalid[i] pulses one cycle later for loads only.
interface dmem_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    wr_en;
    logic [NUM_REQ-1:0]    lock;
    logic [NUM_REQ*32-1:0] addr;
    logic [NUM_REQ*64-1:0] wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rvalid;
    logic [63:0]           rdata;
    logic                  mem_en;
    logic                  mem_wren;
    logic [31:0]           mem_addr;
    logic [63:0]           mem_wdata;
    logic [63:0]           mem_rdata;
    logic                  lock_err;

    modport slave (
        input  req, wr_en, lock, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_wren, mem_addr, mem_wdata, lock_err
    );

    modport master (
        output req, wr_en, lock, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_wren, mem_addr, mem_wdata, lock_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port among NUM_REQ
// requesters, with a bounded lock that lets one requester run atomic sequences.
module dmem_arbiter #(
    parameter int  NUM_REQ  = 4,
    parameter int  LOCK_MAX = 8,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic             dbg_state,
    output logic [IDX_W-1:0] dbg_ptr,
    output logic [CNT_W-1:0] dbg_cnt
);
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;
    logic               ign_valid;
    logic [IDX_W-1:0]   ign_idx;
    logic               lock_err_q;
    logic [NUM_REQ-1:0] rvalid_q;

    logic               hold;
    logic               timeout;
    logic [NUM_REQ-1:0] lock_eff;
    logic               found;
    logic               gnt_any;
    logic [IDX_W-1:0]   win;
    logic [NUM_REQ-1:0] gnt_vec;
    logic               wren_c;
    logic [31:0]        addr_c;
    logic [63:0]        wdata_c;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        return IDX_W'(j);
    endfunction

    // While the owner keeps lock high and its budget is not spent, the port is reserved
    // for it. In the cycle the lock drops or expires, arbitration is already open again.
    assign hold    = (state == LOCKED) && bus.lock[owner] && (cnt != CNT_W'(LOCK_MAX));
    assign timeout = (state == LOCKED) && bus.lock[owner] && (cnt == CNT_W'(LOCK_MAX));

    always_comb begin
        lock_eff = bus.lock;
        if (ign_valid) lock_eff[ign_idx] = 1'b0;
        if (timeout)   lock_eff[owner]   = 1'b0;
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        if (hold) begin
            found = bus.req[owner];
            win   = owner;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && bus.req[wrap_inc(ptr, k)]) begin
                    found = 1'b1;
                    win   = wrap_inc(ptr, k);
                end
            end
        end
    end

    // Gating with reset keeps every output at 0 while reset is held, without an edge.
    assign gnt_any = found && reset;

    always_comb begin
        gnt_vec = '0;
        wren_c  = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        if (gnt_any) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win == IDX_W'(i)) begin
                    gnt_vec[i] = 1'b1;
                    wren_c     = bus.wr_en[i];
                    addr_c     = bus.addr[(NUM_REQ-1-i)*32 +: 32];
                    wdata_c    = bus.wdata[(NUM_REQ-1-i)*64 +: 64];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB;
            ptr        <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            cnt        <= '0;
            ign_valid  <= 1'b0;
            ign_idx    <= '0;
            lock_err_q <= 1'b0;
            rvalid_q   <= '0;
        end else begin
            rvalid_q <= (gnt_any && !wren_c) ? gnt_vec : '0;
            if (gnt_any) ptr <= win;
            if (ign_valid && !bus.lock[ign_idx]) ign_valid <= 1'b0;

            if (hold) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                state <= ARB;
                cnt   <= '0;
                if (timeout) begin
                    lock_err_q <= 1'b1;
                    ign_valid  <= 1'b1;
                    ign_idx    <= owner;
                end
                if (gnt_any && lock_eff[win]) begin
                    state <= LOCKED;
                    owner <= win;
                    cnt   <= CNT_W'(1);
                end
            end
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.mem_en    = gnt_any;
    assign bus.mem_wren  = wren_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = (|rvalid_q) ? bus.mem_rdata : 64'h0;
    assign bus.lock_err  = lock_err_q;

    assign dbg_state = (state == LOCKED);
    assign dbg_ptr   = ptr;
    assign dbg_cnt   = cnt;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.gnt));
    a_gnt_req:    assert property (@(posedge clk) disable iff (!reset) (bus.gnt & ~bus.req) == '0);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: the driver queues expected grants and load returns,
// a negedge monitor pops and compares them whenever the DUT presents gnt or rvalid.
module tb_dmem_arbiter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       dbg_state;
    logic [1:0] dbg_ptr;
    logic [3:0] dbg_cnt;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.NUM_REQ(N)) bus ();

    dmem_arbiter #(.NUM_REQ(N), .LOCK_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr),
        .dbg_cnt   (dbg_cnt)
    );

    // Synchronous memory: data for a load appears one cycle after mem_en.
    logic [63:0] mem_array [16];
    logic [63:0] mem_q = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wren) mem_array[bus.mem_addr[6:3]] <= bus.mem_wdata;
            else              mem_q <= mem_array[bus.mem_addr[6:3]];
        end
    end
    assign bus.mem_rdata = mem_q;

    int tests = 0;
    int fails = 0;

    logic [101:0] gnt_q[$];
    logic [67:0]  rv_q[$];
    logic         pend_rv = 1'b0;
    logic [3:0]   pend_vec = '0;
    logic [63:0]  pend_data = '0;
    logic [31:0]  slot_addr [N];
    logic [63:0]  slot_wdata [N];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Vectors use bit i = requester i. exp_w = -1 means no grant expected this cycle.
    task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
                         input int exp_w, input logic [63:0] exp_rd);
        logic [3:0] e_gnt;
        bus.req   = r;
        bus.wr_en = w;
        bus.lock  = l;
        for (int i = 0; i < N; i++) begin
            bus.addr[(N-1-i)*32 +: 32]  = slot_addr[i];
            bus.wdata[(N-1-i)*64 +: 64] = slot_wdata[i];
        end
        if (pend_rv) rv_q.push_back({pend_vec, pend_data});
        pend_rv = 1'b0;
        if (exp_w >= 0) begin
            e_gnt        = '0;
            e_gnt[exp_w] = 1'b1;
            gnt_q.push_back({e_gnt, 1'b1, w[exp_w], slot_addr[exp_w], slot_wdata[exp_w]});
            if (!w[exp_w]) begin
                pend_rv   = 1'b1;
                pend_vec  = e_gnt;
                pend_data = exp_rd;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [101:0] g_act;
        logic [67:0]  r_act;
        g_act = {bus.gnt, bus.mem_en, bus.mem_wren, bus.mem_addr, bus.mem_wdata};
        r_act = {bus.rvalid, bus.rdata};
        if (bus.gnt != '0) begin
            if (gnt_q.size() == 0) check("unexpected_gnt", 128'(g_act), 128'(0));
            else                   check("grant", 128'(g_act), 128'(gnt_q.pop_front()));
        end else begin
            check("idle_port", 128'(g_act), 128'(0));
        end
        if (bus.rvalid != '0) begin
            if (rv_q.size() == 0) check("unexpected_rvalid", 128'(r_act), 128'(0));
            else                  check("load_data", 128'(r_act), 128'(rv_q.pop_front()));
        end else begin
            check("rdata_idle", 128'(r_act), 128'(0));
        end
    end

    initial begin
        reset     = 1'b0;
        bus.req   = '0;
        bus.wr_en = '0;
        bus.lock  = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        for (int i = 0; i < N; i++) begin
            slot_addr[i]  = 32'h40 + 32'(8 * i);
            slot_wdata[i] = 64'h1000_0000_0000_0000 + 64'(i);
        end

        // Reset state, with requests already present.
        repeat (2) @(posedge clk);
        #1;
        bus.req = 4'b1111;
        #1;
        check("rst_gnt", 128'(bus.gnt), 128'(0));
        check("rst_mem_en", 128'(bus.mem_en), 128'(0));
        check("rst_rvalid", 128'(bus.rvalid), 128'(0));
        check("rst_lock_err", 128'(bus.lock_err), 128'(0));
        check("rst_ptr", 128'(dbg_ptr), 128'(3));
        check("rst_state", 128'(dbg_state), 128'(0));
        reset = 1'b1;

        // All four requesting: rotation starts at requester 0 (stores fill mem[8..11]).
        for (int i = 0; i < N; i++) drive(4'b1111, 4'b1111, 4'b0000, i, 64'h0);

        // Store then load at 0x10; further loads return earlier stores.
        slot_addr[0]  = 32'h10;
        slot_wdata[0] = 64'hDEAD_BEEF_0000_0001;
        drive(4'b0001, 4'b0001, 4'b0000, 0, 64'h0);
        slot_addr[2] = 32'h10;
        drive(4'b0100, 4'b0000, 4'b0000, 2, 64'hDEAD_BEEF_0000_0001);
        drive(4'b1010, 4'b0000, 4'b0000, 3, 64'h1000_0000_0000_0003);
        drive(4'b0010, 4'b0000, 4'b0000, 1, 64'h1000_0000_0000_0001);

        // Idle cycles leave the pointer alone; then a lone request wins immediately.
        repeat (5) drive(4'b0000, 4'b0000, 4'b0000, -1, 64'h0);
        check("idle_ptr_hold", 128'(dbg_ptr), 128'(1));
        slot_wdata[0] = 64'h5555;
        drive(4'b0001, 4'b0001, 4'b0000, 0, 64'h0);
        drive(4'b0100, 4'b0000, 4'b0000, 2, 64'h5555);

        // Requester 1 locks for three cycles, then rotation resumes at requester 2.
        drive(4'b0001, 4'b1111, 4'b0000, 0, 64'h0);
        drive(4'b1111, 4'b1111, 4'b0010, 1, 64'h0);
        check("lock_entered", 128'(dbg_state), 128'(1));
        drive(4'b1111, 4'b1111, 4'b0010, 1, 64'h0);
        drive(4'b1111, 4'b1111, 4'b0010, 1, 64'h0);
        check("lock_cnt", 128'(dbg_cnt), 128'(3));
        drive(4'b1111, 4'b1111, 4'b0000, 2, 64'h0);
        check("lock_released", 128'(dbg_state), 128'(0));
        drive(4'b1111, 4'b1111, 4'b0000, 3, 64'h0);
        check("no_lock_err", 128'(bus.lock_err), 128'(0));

        // Requester 3 holds lock past LOCK_MAX: 8 grants, then forced release.
        drive(4'b1000, 4'b1111, 4'b1000, 3, 64'h0);
        repeat (7) drive(4'b1111, 4'b1111, 4'b1000, 3, 64'h0);
        check("lock_at_max_state", 128'(dbg_state), 128'(1));
        check("lock_at_max_cnt", 128'(dbg_cnt), 128'(8));
        check("lock_err_before", 128'(bus.lock_err), 128'(0));
        drive(4'b1111, 4'b1111, 4'b1000, 0, 64'h0);
        check("lock_err_set", 128'(bus.lock_err), 128'(1));
        check("timeout_state", 128'(dbg_state), 128'(0));
        drive(4'b1111, 4'b1111, 4'b1000, 1, 64'h0);
        drive(4'b1111, 4'b1111, 4'b1000, 2, 64'h0);
        drive(4'b1111, 4'b1111, 4'b1000, 3, 64'h0);
        check("stale_lock_ignored", 128'(dbg_state), 128'(0));
        drive(4'b0000, 4'b0000, 4'b0000, -1, 64'h0);
        drive(4'b1000, 4'b1111, 4'b1000, 3, 64'h0);
        check("relock_after_drop", 128'(dbg_state), 128'(1));
        drive(4'b1111, 4'b1111, 4'b1000, 3, 64'h0);
        drive(4'b1111, 4'b1111, 4'b0000, 0, 64'h0);
        check("relock_released", 128'(dbg_state), 128'(0));

        // Reset lands while a load result is on the bus.
        slot_addr[1] = 32'h40;
        drive(4'b0010, 4'b0000, 4'b0000, 1, 64'h1000_0000_0000_0000);
        check("pre_rst_rvalid", 128'(bus.rvalid), 128'(4'b0010));
        check("pre_rst_rdata", 128'(bus.rdata), 128'(64'h1000_0000_0000_0000));
        check("pre_rst_lock_err", 128'(bus.lock_err), 128'(1));
        reset   = 1'b0;
        pend_rv = 1'b0;
        #1;
        check("async_rst_rvalid", 128'(bus.rvalid), 128'(0));
        check("async_rst_rdata", 128'(bus.rdata), 128'(0));
        check("async_rst_gnt", 128'(bus.gnt), 128'(0));
        check("async_rst_lock_err", 128'(bus.lock_err), 128'(0));
        check("async_rst_ptr", 128'(dbg_ptr), 128'(3));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(4'b0010, 4'b0010, 4'b0000, 1, 64'h0);
        repeat (2) drive(4'b0000, 4'b0000, 4'b0000, -1, 64'h0);

        check("gnt_q_drained", 128'(gnt_q.size()), 128'(0));
        check("rv_q_drained", 128'(rv_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
